// File: rtl/mux_n_stream_if.sv
// Stream bundle for mux_n_stream: NUM_CH valid/ready inputs, one registered valid/ready output,
// plus the mode/select controls that steer the grant.
interface mux_n_stream_if #(
   parameter int WIDTH  = 64,
   parameter int NUM_CH = 4
);
   localparam int SEL_W = $clog2(NUM_CH);

   logic                     mode;
   logic [SEL_W-1:0]         sel;
   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH*WIDTH-1:0]  in_data;
   logic [NUM_CH-1:0]        in_ready;
   logic                     out_valid;
   logic [WIDTH-1:0]         out_data;
   logic [SEL_W-1:0]         out_ch;
   logic                     out_ready;

   // master drives the inputs and consumes the output stream; slave is the mux itself
   modport master (
      output mode, sel, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_ch
   );

   modport slave (
      input  mode, sel, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_ch
   );
endinterface

// File: rtl/mux_n_stream.sv
// N-channel registered stream mux with explicit-select or round-robin grant and one output stage.
// Define MUX_N_STREAM_CNT_EN to add saturating per-channel transfer counters (clr_cnt/grant_cnt).
module mux_n_stream #(
   parameter int WIDTH  = 64,
   parameter int NUM_CH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
`ifdef MUX_N_STREAM_CNT_EN
   input  logic                 clr_cnt,
   output logic [NUM_CH*16-1:0] grant_cnt,
`endif
   mux_n_stream_if.slave        bus
);
   localparam int SEL_W = $clog2(NUM_CH);

   logic [SEL_W-1:0]  rr_last;
   logic [SEL_W-1:0]  grant;
   logic              grant_hit;
   logic              load;
   logic              xfer;
   logic [WIDTH-1:0]  grant_data;
   logic [NUM_CH-1:0] in_ready_w;
   int                best_dist;

   logic              out_valid_q;
   logic [WIDTH-1:0]  out_data_q;
   logic [SEL_W-1:0]  out_ch_q;

   // Distance of channel c from the round-robin start point rr_last+1 (0 = highest priority).
   function automatic int rr_dist(input int c, input logic [SEL_W-1:0] last);
      return (c - int'(last) - 1 + NUM_CH) % NUM_CH;
   endfunction

   assign load = ~out_valid_q | bus.out_ready;

   // NOTE: every signal written here gets a default first, so no path can leave it unassigned
   // and infer a latch.
   always_comb begin
      grant     = '0;
      grant_hit = 1'b0;
      best_dist = NUM_CH;
      if (!bus.mode) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (bus.sel == SEL_W'(c) && bus.in_valid[c]) begin
               grant     = SEL_W'(c);
               grant_hit = 1'b1;
            end
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (bus.in_valid[c] && rr_dist(c, rr_last) < best_dist) begin
               best_dist = rr_dist(c, rr_last);
               grant     = SEL_W'(c);
               grant_hit = 1'b1;
            end
         end
      end
   end

   // Reset gates in_ready so nothing is accepted while the output stage is held in reset.
   always_comb begin
      in_ready_w = '0;
      grant_data = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (grant == SEL_W'(c)) begin
            in_ready_w[c] = reset & load & grant_hit;
            grant_data    = bus.in_data[c*WIDTH +: WIDTH];
         end
      end
   end

   assign xfer = |in_ready_w;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         rr_last     <= SEL_W'(NUM_CH - 1);
      end else begin
         if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= grant_data;
            out_ch_q    <= grant;
            if (bus.mode) rr_last <= grant;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;

`ifdef MUX_N_STREAM_CNT_EN
   logic [15:0] cnt [NUM_CH];

   // NOTE: the counter array is a few flops per channel, not a RAM, so every entry is reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      end else if (clr_cnt) begin
         for (int c = 0; c < NUM_CH; c++) cnt[c] <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (xfer && grant == SEL_W'(c) && cnt[c] != 16'hFFFF) cnt[c] <= cnt[c] + 16'd1;
         end
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int c = 0; c < NUM_CH; c++) grant_cnt[c*16 +: 16] = cnt[c];
   end
`endif
endmodule

// File: tb/tb_mux_n_stream.sv
// Scoreboard bench for mux_n_stream: a reference grant model predicts in_ready and queues the
// expected beats, which are compared against the output register while it holds them.
module tb_mux_n_stream;
   localparam int WIDTH  = 64;
   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef struct {
      logic [SEL_W-1:0] ch;
      logic [WIDTH-1:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mux_n_stream_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) bus ();

`ifdef MUX_N_STREAM_CNT_EN
   logic                 clr_cnt;
   logic [NUM_CH*16-1:0] grant_cnt;
`endif

   mux_n_stream #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
      .clk       (clk),
      .reset     (reset),
`ifdef MUX_N_STREAM_CNT_EN
      .clr_cnt   (clr_cnt),
      .grant_cnt (grant_cnt),
`endif
      .bus       (bus)
   );

   int    total = 0;
   int    bad   = 0;
   beat_t sb[$];
   logic  m_ov;
   int    m_rr;
   int    m_cnt[NUM_CH];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference grant: -1 when nothing is eligible.
   function automatic int model_grant();
      int   g;
      int   c;
      logic [NUM_CH-1:0] v;
      g = -1;
      v = bus.in_valid;
      if (bus.mode == 1'b0) begin
         if (int'(bus.sel) < NUM_CH && v[bus.sel]) g = int'(bus.sel);
      end else begin
         for (int k = 1; k <= NUM_CH; k++) begin
            c = (m_rr + k) % NUM_CH;
            if (g < 0 && v[c[SEL_W-1:0]]) g = c;
         end
      end
      return g;
   endfunction

   task automatic model_reset();
      m_ov = 1'b0;
      m_rr = NUM_CH - 1;
      sb.delete();
      for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
   endtask

   // One clock: check handshake and held beat, update the model, advance past the edge.
   task automatic cycle(input string tag);
      int                g;
      logic              ld;
      logic [NUM_CH-1:0] exp_rdy;
      beat_t             b;
      #1;
      g       = model_grant();
      ld      = !m_ov || bus.out_ready;
      exp_rdy = '0;
      if (ld && g >= 0) exp_rdy[g[SEL_W-1:0]] = 1'b1;
      check({tag, ".in_ready"}, 64'(bus.in_ready), 64'(exp_rdy));
      check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(m_ov));
      if (m_ov) begin
         if (sb.size() == 0) begin
            check({tag, ".sb_depth"}, 64'(sb.size()), 64'd1);
         end else begin
            check({tag, ".out_data"}, bus.out_data, sb[0].data);
            check({tag, ".out_ch"}, 64'(bus.out_ch), 64'(sb[0].ch));
            if (bus.out_ready) void'(sb.pop_front());
         end
      end
      if (exp_rdy != '0) begin
         b.ch   = g[SEL_W-1:0];
         b.data = bus.in_data[g*WIDTH +: WIDTH];
         sb.push_back(b);
         if (bus.mode) m_rr = g;
         m_ov = 1'b1;
      end else if (bus.out_ready) begin
         m_ov = 1'b0;
      end
`ifdef MUX_N_STREAM_CNT_EN
      if (clr_cnt) begin
         for (int i = 0; i < NUM_CH; i++) m_cnt[i] = 0;
      end else if (exp_rdy != '0 && m_cnt[g] < 65535) begin
         m_cnt[g]++;
      end
`endif
      @(posedge clk);
      #1;
`ifdef MUX_N_STREAM_CNT_EN
      begin
         logic [NUM_CH*16-1:0] ev;
         for (int i = 0; i < NUM_CH; i++) ev[i*16 +: 16] = 16'(m_cnt[i]);
         check({tag, ".grant_cnt"}, 64'(grant_cnt), 64'(ev));
      end
`endif
   endtask

   // Asserts reset away from the clock edge and checks outputs clear without a clock.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, ".out_data"}, bus.out_data, 64'd0);
      check({tag, ".out_ch"}, 64'(bus.out_ch), 64'd0);
      check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      check({tag, ".in_ready_hold"}, 64'(bus.in_ready), 64'd0);
      reset = 1'b1;
   endtask

   task automatic fill_data(input logic [31:0] tag);
      for (int i = 0; i < NUM_CH; i++) bus.in_data[i*WIDTH +: WIDTH] = {tag, 32'(i + 1)};
   endtask

   int rr_seq[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1, 3};

   initial begin
      bus.mode      = 1'b1;
      bus.sel       = '0;
      bus.in_valid  = 4'b1111;
      bus.out_ready = 1'b1;
      fill_data(32'hA000_0000);
`ifdef MUX_N_STREAM_CNT_EN
      clr_cnt = 1'b0;
`endif
      #2;
      do_reset("rst");

      // first round-robin grant after reset is channel 0
      #1;
      check("rst.first_rr", 64'(bus.in_ready), 64'b0001);
      cycle("rst_rr");

      // explicit select of channel 2
      bus.mode = 1'b0;
      bus.sel  = 2'd2;
      bus.in_data[2*WIDTH +: WIDTH] = 64'hDEAD_BEEF;
      #1;
      check("sel.in_ready", 64'(bus.in_ready), 64'b0100);
      cycle("sel");
      check("sel.out_valid_c", 64'(bus.out_valid), 64'd1);
      check("sel.out_data_c", bus.out_data, 64'hDEAD_BEEF);
      check("sel.out_ch_c", 64'(bus.out_ch), 64'd2);
      bus.in_valid = 4'b1011;
      #1;
      check("sel_miss.in_ready", 64'(bus.in_ready), 64'd0);
      cycle("sel_miss");

      // backpressure: hold a channel-1 beat for 5 cycles while inputs churn
      bus.sel      = 2'd1;
      bus.in_valid = 4'b0010;
      fill_data(32'hB000_0000);
      cycle("bp_load");
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.mode     = 1'($urandom);
         bus.sel      = SEL_W'($urandom);
         bus.in_valid = NUM_CH'($urandom) | 4'b0001;
         fill_data($urandom);
         cycle("bp_hold");
         check("bp.out_ch_c", 64'(bus.out_ch), 64'd1);
      end
      bus.mode      = 1'b0;
      bus.sel       = 2'd3;
      bus.in_valid  = 4'b1000;
      bus.out_ready = 1'b1;
      cycle("bp_release");
      check("bp.reload_ch", 64'(bus.out_ch), 64'd3);

      // mid-operation reset while a beat is held and another is being accepted
      bus.mode     = 1'b1;
      bus.in_valid = 4'b1111;
      fill_data(32'hC000_0000);
      cycle("mid_pre");
      cycle("mid_pre");
      #2;
      do_reset("mid_rst");

      // round-robin fairness: all valid, then alternate channels 1 and 3
      for (int k = 0; k < 12; k++) begin
         bus.in_valid = (k < 8) ? 4'b1111 : 4'b1010;
         fill_data(32'hD000_0000 + 32'(k));
         cycle("rr");
         check($sformatf("rr.seq%0d", k), 64'(bus.out_ch), 64'(rr_seq[k]));
      end

      // random mix of modes, selects, valids and backpressure
      for (int i = 0; i < 200; i++) begin
         bus.mode      = 1'($urandom);
         bus.sel       = SEL_W'($urandom);
         bus.in_valid  = NUM_CH'($urandom);
         bus.out_ready = ($urandom_range(3) != 0);
         fill_data($urandom);
         cycle("rand");
      end
      bus.in_valid  = '0;
      bus.out_ready = 1'b1;
      cycle("drain");
      cycle("drain");

`ifdef MUX_N_STREAM_CNT_EN
      clr_cnt = 1'b1;
      cycle("cnt_clr");
      clr_cnt      = 1'b0;
      bus.mode     = 1'b0;
      bus.sel      = 2'd3;
      bus.in_valid = 4'b1000;
      for (int i = 0; i < 3; i++) cycle("cnt_inc");
      check("cnt.three", 64'(grant_cnt[3*16 +: 16]), 64'd3);
      clr_cnt = 1'b1;
      cycle("cnt_clr_xfer");
      check("cnt.clr_wins", 64'(grant_cnt[3*16 +: 16]), 64'd0);
      clr_cnt = 1'b0;
      for (int i = 0; i < 65540; i++) cycle("cnt_sat");
      check("cnt.saturate", 64'(grant_cnt[3*16 +: 16]), 64'hFFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
